// File: rtl/bin_display_scanner.sv
// Binary-to-BCD converter using shift-add-3, feeding a 4-digit multiplexed display scanner.
// Optional macro LEADING_ZERO_BLANK_EN blanks leading zero digits (bcd = 4'hF).
module bin_display_scanner #(
    parameter int REFRESH_DIV = 50000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [13:0] value_in,
    input  logic        value_valid,
    output logic        busy,
    output logic        ovf,
    output logic [3:0]  an,
    output logic [3:0]  bcd
);

    typedef enum logic [1:0] {IDLE, CONV, LOAD} state_t;

    localparam int PW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [PW-1:0] PRE_MAX = PW'(REFRESH_DIV - 1);

    state_t        state_q, state_d;
    logic [29:0]   shift_q, shift_d, shift_adj;
    logic [3:0]    iter_q, iter_d;
    logic          ovf_q, ovf_d;
    logic [15:0]   disp_q, disp_d;
    logic [PW-1:0] pre_q, pre_d;
    logic          tick;
    logic [1:0]    sel_q, sel_d;
    logic [3:0]    an_q, an_d;
    logic [3:0]    bcd_q, bcd_d;
    logic [3:0]    digit;

    // Shift register layout: BCD digits in [29:14], remaining binary bits in [13:0].
    always_comb begin
        shift_adj = shift_q;
        for (int i = 0; i < 4; i++) begin
            if (shift_q[14 + 4*i +: 4] >= 4'd5) begin
                shift_adj[14 + 4*i +: 4] = shift_q[14 + 4*i +: 4] + 4'd3;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        iter_d  = iter_q;
        ovf_d   = ovf_q;
        disp_d  = disp_q;
        case (state_q)
            IDLE: begin
                if (value_valid) begin
                    shift_d = {16'd0, (value_in > 14'd9999) ? 14'd9999 : value_in};
                    iter_d  = 4'd0;
                    ovf_d   = (value_in > 14'd9999);
                    state_d = CONV;
                end
            end
            CONV: begin
                shift_d = {shift_adj[28:0], 1'b0};
                iter_d  = iter_q + 4'd1;
                if (iter_q == 4'd13) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                disp_d  = shift_q[29:14];
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        tick  = (pre_q == PRE_MAX);
        pre_d = tick ? '0 : pre_q + 1'b1;
        sel_d = tick ? sel_q + 2'd1 : sel_q;
        an_d  = ~(4'b0001 << sel_q);
        digit = disp_q[{sel_q, 2'b00} +: 4];
`ifdef LEADING_ZERO_BLANK_EN
        case (sel_q)
            2'd3:    bcd_d = (disp_q[15:12] == 4'd0)  ? 4'hF : digit;
            2'd2:    bcd_d = (disp_q[15:8]  == 8'd0)  ? 4'hF : digit;
            2'd1:    bcd_d = (disp_q[15:4]  == 12'd0) ? 4'hF : digit;
            default: bcd_d = digit;
        endcase
`else
        bcd_d = digit;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            shift_q <= '0;
            iter_q  <= '0;
            ovf_q   <= 1'b0;
            disp_q  <= '0;
            pre_q   <= '0;
            sel_q   <= '0;
            an_q    <= 4'b1110;
            bcd_q   <= 4'h0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            iter_q  <= iter_d;
            ovf_q   <= ovf_d;
            disp_q  <= disp_d;
            pre_q   <= pre_d;
            sel_q   <= sel_d;
            an_q    <= an_d;
            bcd_q   <= bcd_d;
        end
    end

    assign busy = (state_q != IDLE);
    assign ovf  = ovf_q;
    assign an   = an_q;
    assign bcd  = bcd_q;

endmodule

// File: tb/tb_bin_display_scanner.sv
// Self-checking bench for bin_display_scanner: vector table, hand-written corner cases,
// and randomized loads compared against an arithmetic decimal/scan model.
module tb_bin_display_scanner;

    localparam int DIV = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [13:0] value_in;
    logic        value_valid;
    logic        busy;
    logic        ovf;
    logic [3:0]  an;
    logic [3:0]  bcd;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef struct {
        logic [13:0] value;
        logic        exp_ovf;
        logic [15:0] exp_bcd;
    } vec_t;

    vec_t vecs[9];

    always #5 clk = ~clk;

    bin_display_scanner #(.REFRESH_DIV(DIV)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .value_in    (value_in),
        .value_valid (value_valid),
        .busy        (busy),
        .ovf         (ovf),
        .an          (an),
        .bcd         (bcd)
    );

    function automatic logic [15:0] to_bcd(input int v);
        int c;
        c = (v > 9999) ? 9999 : v;
        return {4'(c / 1000), 4'((c / 100) % 10), 4'((c / 10) % 10), 4'(c % 10)};
    endfunction

    function automatic logic [3:0] exp_digit(input logic [15:0] d, input int pos);
`ifdef LEADING_ZERO_BLANK_EN
        if (pos > 0 && (d >> (4 * pos)) == 16'd0) return 4'hF;
`endif
        return d[4*pos +: 4];
    endfunction

    task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    // Scan phase is a pure function of cycles since reset release.
    task automatic checkScan(input logic [15:0] d, input logic exp_ovf, input string tag);
        int s;
        checkOutput({tag, " ovf"}, {15'd0, ovf}, {15'd0, exp_ovf});
        for (int i = 0; i < 16; i++) begin
            s = (cyc == 0) ? 0 : ((cyc - 1) / DIV) % 4;
            checkOutput({tag, " an"},  {12'd0, an},  {12'd0, 4'(~(4'b0001 << s))});
            checkOutput({tag, " bcd"}, {12'd0, bcd}, {12'd0, exp_digit(d, s)});
            step();
        end
    endtask

    task automatic doReset(input string tag);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput({tag, " reset an"},   {12'd0, an},  16'h000E);
        checkOutput({tag, " reset bcd"},  {12'd0, bcd}, 16'h0000);
        checkOutput({tag, " reset busy"}, {15'd0, busy}, 16'h0000);
        checkOutput({tag, " reset ovf"},  {15'd0, ovf},  16'h0000);
        step();
        step();
        rst_n = 1'b1;
        cyc   = 0;
    endtask

    // Load at edge N; busy must read high after edges N..N+14 and low after N+15.
    task automatic applyStimulus(input logic [13:0] v, input int inject_at);
        value_in    = v;
        value_valid = 1'b1;
        step();
        value_valid = 1'b0;
        for (int i = 1; i <= 15; i++) begin
            checkOutput("busy during conversion", {15'd0, busy}, 16'h0001);
            if (i == inject_at) begin
                value_in    = 14'd42;
                value_valid = 1'b1;
            end
            step();
            value_valid = 1'b0;
        end
        checkOutput("busy after load", {15'd0, busy}, 16'h0000);
        step();
    endtask

    initial begin
        int v;
        vecs[0] = '{14'd1234,  1'b0, 16'h1234};
        vecs[1] = '{14'd12000, 1'b1, 16'h9999};
        vecs[2] = '{14'd5,     1'b0, 16'h0005};
        vecs[3] = '{14'd0,     1'b0, 16'h0000};
        vecs[4] = '{14'd9999,  1'b0, 16'h9999};
        vecs[5] = '{14'd10000, 1'b1, 16'h9999};
        vecs[6] = '{14'd16383, 1'b1, 16'h9999};
        vecs[7] = '{14'd100,   1'b0, 16'h0100};
        vecs[8] = '{14'd7,     1'b0, 16'h0007};

        rst_n       = 1'b1;
        value_valid = 1'b0;
        value_in    = '0;
        #2;
        doReset("power-on");
        checkScan(16'h0000, 1'b0, "after reset");

        foreach (vecs[k]) begin
            applyStimulus(vecs[k].value, 0);
            checkScan(vecs[k].exp_bcd, vecs[k].exp_ovf, $sformatf("vec%0d", k));
        end

        // A strobe while busy must neither alter nor queue behind the running conversion.
        applyStimulus(14'd100, 5);
        checkScan(16'h0100, 1'b0, "ignored strobe");
        checkOutput("no queued load", {15'd0, busy}, 16'h0000);

        for (int r = 0; r < 12; r++) begin
            v = $urandom_range(0, 16383);
            applyStimulus(14'(v), 0);
            checkScan(to_bcd(v), (v > 9999), $sformatf("rand%0d(%0d)", r, v));
        end

        // Reset mid-conversion aborts it and leaves the display at zero.
        applyStimulus(14'd12000, 0);
        value_in    = 14'd1234;
        value_valid = 1'b1;
        step();
        value_valid = 1'b0;
        for (int i = 0; i < 5; i++) step();
        checkOutput("busy before abort", {15'd0, busy}, 16'h0001);
        doReset("mid-conversion");
        for (int i = 0; i < 20; i++) step();
        checkOutput("busy after abort", {15'd0, busy}, 16'h0000);
        checkScan(16'h0000, 1'b0, "after abort");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
